// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster timing generator: default
// 640x480@60 timing, the pixel colour type and the total-length helper.
package vga_pkg;

    // Raster counter width; line and frame totals must fit in it.
    localparam int CNT_W = 10;
    localparam int CNT_MAX_TOT = 1 << CNT_W;

    // Default timing: 640x480@60 with a 25 MHz pixel rate from 50 MHz.
    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;

    // One pixel as delivered to the DAC.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Total length of a line or frame from its four segments.
    function automatic int calc_tot(input int disp, input int fp,
                                    input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// Generic raster counter for one axis. Segments run display, front porch,
// sync, back porch; the count advances on en_i and wraps after the last one.
module vga_sync_cnt
    import vga_pkg::*;
#(
    parameter int DISP = DEF_H_DISP,
    parameter int FP   = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP   = DEF_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             active_o,
    output logic             sync_n_o,
    output logic             wrap_o
);

    localparam int TOT = calc_tot(DISP, FP, SYNC, BP);

    // Compare one bit wider so a segment boundary equal to 1024 still works.
    localparam logic [CNT_W:0] LAST      = (CNT_W+1)'(TOT - 1);
    localparam logic [CNT_W:0] ACT_END   = (CNT_W+1)'(DISP);
    localparam logic [CNT_W:0] SYNC_BEG  = (CNT_W+1)'(DISP + FP);
    localparam logic [CNT_W:0] SYNC_END  = (CNT_W+1)'(DISP + FP + SYNC);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W:0]   count_ext;
    logic             at_last;

    assign count_ext = {1'b0, count_q};
    assign at_last   = (count_ext == LAST);

    // Next count: hold unless enabled, wrap to zero after the last position.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = (count_ext < ACT_END);
    assign sync_n_o = !((count_ext >= SYNC_BEG) && (count_ext < SYNC_END));
    assign wrap_o   = en_i & at_last;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator for the ADV7123 DAC. Stage 0 requests pixels
// from the frame source; stage 1 registers sync, blank and colour one pixel
// tick later so all DAC signals stay aligned.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] pix_x_o,
    output logic [CNT_W-1:0] pix_y_o,
    output logic             pix_req_o,
    input  logic [7:0]       pix_r_i,
    input  logic [7:0]       pix_g_i,
    input  logic [7:0]       pix_b_i,
    output logic             frame_start_o,
    output logic             vga_clk_o,
    output logic             vga_hs_o,
    output logic             vga_vs_o,
    output logic             vga_blank_o,
    output logic             vga_sync_o,
    output logic [7:0]       vga_r_o,
    output logic [7:0]       vga_g_o,
    output logic [7:0]       vga_b_o
);

    localparam int H_TOT = calc_tot(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_tot(V_DISP, V_FP, V_SYNC, V_BP);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("vga_timing: CLK_DIV must be even and at least 2");
    end
    if (H_TOT > CNT_MAX_TOT || V_TOT > CNT_MAX_TOT) begin : g_bad_tot
        $error("vga_timing: line or frame total exceeds the 10-bit counters");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             vga_clk_q, vga_clk_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    rgb_t             rgb_q, rgb_d;

    logic             tick;
    logic             advance;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_active, v_active;
    logic             h_sync_n, v_sync_n;
    logic             h_wrap;
    logic             frame_wrap_unused;
    logic             pix_req;
    rgb_t             pix_rgb;

    assign tick    = (div_cnt_q == DIV_LAST);
    // The very first tick only arms the raster, so pixel (0,0) gets a full slot.
    assign advance = tick & running_q;

    vga_sync_cnt #(
        .DISP (H_DISP),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (advance),
        .count_o  (h_cnt),
        .active_o (h_active),
        .sync_n_o (h_sync_n),
        .wrap_o   (h_wrap)
    );

    vga_sync_cnt #(
        .DISP (V_DISP),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (h_wrap),
        .count_o  (v_cnt),
        .active_o (v_active),
        .sync_n_o (v_sync_n),
        .wrap_o   (frame_wrap_unused)
    );

    assign pix_req = running_q & h_active & v_active;
    assign pix_rgb = {pix_r_i, pix_g_i, pix_b_i};

    // Next-state for divider, pixel clock, run flag, coordinate hold and stage 1.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        // Registered from the next divider value so vga_clk tracks div_cnt exactly.
        vga_clk_d = (div_cnt_d >= DIV_HALF);
        running_d = running_q | tick;
        pix_x_d   = pix_req ? h_cnt : pix_x_q;
        pix_y_d   = pix_req ? v_cnt : pix_y_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_d   = blank_q;
        rgb_d     = rgb_q;
        if (tick) begin
            hs_d    = h_sync_n;
            vs_d    = v_sync_n;
            blank_d = pix_req;
            rgb_d   = pix_req ? pix_rgb : '0;
        end
    end

    // State registers; reset leaves the DAC blanked with syncs idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            vga_clk_q <= 1'b0;
            running_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_q   <= 1'b0;
            rgb_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            vga_clk_q <= vga_clk_d;
            running_q <= running_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_q   <= blank_d;
            rgb_q     <= rgb_d;
        end
    end

    // Coordinates follow the counters while requesting, else show the last request.
    assign pix_x_o       = pix_req ? h_cnt : pix_x_q;
    assign pix_y_o       = pix_req ? v_cnt : pix_y_q;
    assign pix_req_o     = pix_req;
    assign frame_start_o = running_q & tick & (h_cnt == '0) & (v_cnt == '0);

    assign vga_clk_o   = vga_clk_q;
    assign vga_hs_o    = hs_q;
    assign vga_vs_o    = vs_q;
    assign vga_blank_o = blank_q;
    assign vga_sync_o  = 1'b0;
    assign vga_r_o     = rgb_q.r;
    assign vga_g_o     = rgb_q.g;
    assign vga_b_o     = rgb_q.b;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default timing, small timing, small
// timing at CLK_DIV=4) checked every clk against an arithmetic raster model,
// plus literal timing measurements and random mid-frame resets.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       preq [3];
    logic       fs [3];
    logic       vclk [3];
    logic       hs [3];
    logic       vs [3];
    logic       blank [3];
    logic       sync [3];
    logic [7:0] pr [3];
    logic [7:0] pg [3];
    logic [7:0] pb [3];
    logic [7:0] vr [3];
    logic [7:0] vg [3];
    logic [7:0] vb [3];

    localparam int CD [3] = '{2, 2, 4};
    localparam int HD [3] = '{640, 8, 8};
    localparam int HF [3] = '{16, 2, 2};
    localparam int HS [3] = '{96, 2, 2};
    localparam int HB [3] = '{48, 2, 2};
    localparam int VD [3] = '{480, 4, 4};
    localparam int VF [3] = '{10, 1, 1};
    localparam int VS [3] = '{2, 1, 1};
    localparam int VB [3] = '{33, 1, 1};

    vga_timing u_def (
        .clk_i(clk), .rst_i(rst),
        .pix_x_o(px[0]), .pix_y_o(py[0]), .pix_req_o(preq[0]),
        .pix_r_i(pr[0]), .pix_g_i(pg[0]), .pix_b_i(pb[0]),
        .frame_start_o(fs[0]), .vga_clk_o(vclk[0]), .vga_hs_o(hs[0]),
        .vga_vs_o(vs[0]), .vga_blank_o(blank[0]), .vga_sync_o(sync[0]),
        .vga_r_o(vr[0]), .vga_g_o(vg[0]), .vga_b_o(vb[0])
    );

    vga_timing #(
        .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk_i(clk), .rst_i(rst),
        .pix_x_o(px[1]), .pix_y_o(py[1]), .pix_req_o(preq[1]),
        .pix_r_i(pr[1]), .pix_g_i(pg[1]), .pix_b_i(pb[1]),
        .frame_start_o(fs[1]), .vga_clk_o(vclk[1]), .vga_hs_o(hs[1]),
        .vga_vs_o(vs[1]), .vga_blank_o(blank[1]), .vga_sync_o(sync[1]),
        .vga_r_o(vr[1]), .vga_g_o(vg[1]), .vga_b_o(vb[1])
    );

    vga_timing #(
        .CLK_DIV(4), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml4 (
        .clk_i(clk), .rst_i(rst),
        .pix_x_o(px[2]), .pix_y_o(py[2]), .pix_req_o(preq[2]),
        .pix_r_i(pr[2]), .pix_g_i(pg[2]), .pix_b_i(pb[2]),
        .frame_start_o(fs[2]), .vga_clk_o(vclk[2]), .vga_hs_o(hs[2]),
        .vga_vs_o(vs[2]), .vga_blank_o(blank[2]), .vga_sync_o(sync[2]),
        .vga_r_o(vr[2]), .vga_g_o(vg[2]), .vga_b_o(vb[2])
    );

    int checks = 0;
    int errors = 0;
    int n = -1;   // clk intervals since the last clk edge that saw rst=1

    typedef struct packed {
        bit       req;
        bit       fs;
        bit       vclk;
        bit       hs;
        bit       vs;
        bit       blank;
        int       h;
        int       v;
        bit [7:0] r;
        bit [7:0] g;
        bit [7:0] b;
    } exp_t;

    // Raster model: interval n after reset. The first pixel tick arms the
    // raster, so pixel p occupies intervals [D*(p+1), D*(p+2)); stage 1 shows
    // pixel p-1 during pixel p's slot.
    function automatic exp_t model(input int i, input int t);
        exp_t e;
        int d, ht, vt, p, q, hq, vq;
        d  = CD[i];
        ht = HD[i] + HF[i] + HS[i] + HB[i];
        vt = VD[i] + VF[i] + VS[i] + VB[i];
        e = '0;
        e.vclk = ((t % d) >= (d / 2));
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (t >= d) begin
            p = (t - d) / d;
            e.h = p % ht;
            e.v = (p / ht) % vt;
            e.req = (e.h < HD[i]) && (e.v < VD[i]);
            e.fs = ((t % d) == d - 1) && (e.h == 0) && (e.v == 0);
        end
        if (t >= 2 * d) begin
            q  = (t - d) / d - 1;
            hq = q % ht;
            vq = (q / ht) % vt;
            e.hs = !((hq >= HD[i] + HF[i]) && (hq < HD[i] + HF[i] + HS[i]));
            e.vs = !((vq >= VD[i] + VF[i]) && (vq < VD[i] + VF[i] + VS[i]));
            e.blank = (hq < HD[i]) && (vq < VD[i]);
            if (e.blank) begin
                e.r = 8'(hq);
                e.g = 8'(vq);
                e.b = 8'hA5;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int i,
                       input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s inst=%0d n=%0d got=%0h want=%0h", name, i, n, act, want);
        end
    endtask

    // Interval counter used by the model.
    always @(posedge clk) begin
        if (rst) n = 0;
        else if (n >= 0) n = n + 1;
    end

    // Frame source: returns {x, y, A5} one clk after seeing the request.
    logic [9:0] sx [3];
    logic [9:0] sy [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            pr[i] = 8'h00; pg[i] = 8'h00; pb[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                sx[i] = px[i];
                sy[i] = py[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                pr[i] = sx[i][7:0];
                pg[i] = sy[i][7:0];
                pb[i] = 8'hA5;
            end
        end
    end

    // Measurements that pin the model with hand-computed numbers.
    int fs_first [3];
    int fs_second [3];
    int hs_fall1, hs_fall2, hs_rise1;
    bit hs_prev;
    int lx [3];
    int ly [3];

    // Per-clk comparison of every output of every instance against the model.
    always @(negedge clk) begin : compare
        exp_t e;
        if (n >= 0) begin
            if (n == 0) begin
                for (int i = 0; i < 3; i++) begin
                    lx[i] = 0; ly[i] = 0;
                    fs_first[i] = -1; fs_second[i] = -1;
                end
                hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; hs_prev = 1'b1;
            end
            for (int i = 0; i < 3; i++) begin
                e = model(i, n);
                chk("pix_req", i, 32'(preq[i]), 32'(e.req));
                chk("pix_x", i, 32'(px[i]), e.req ? e.h : lx[i]);
                chk("pix_y", i, 32'(py[i]), e.req ? e.v : ly[i]);
                chk("frame_start", i, 32'(fs[i]), 32'(e.fs));
                chk("vga_clk", i, 32'(vclk[i]), 32'(e.vclk));
                chk("vga_hs", i, 32'(hs[i]), 32'(e.hs));
                chk("vga_vs", i, 32'(vs[i]), 32'(e.vs));
                chk("vga_blank", i, 32'(blank[i]), 32'(e.blank));
                chk("vga_sync", i, 32'(sync[i]), 32'd0);
                chk("vga_r", i, 32'(vr[i]), 32'(e.r));
                chk("vga_g", i, 32'(vg[i]), 32'(e.g));
                chk("vga_b", i, 32'(vb[i]), 32'(e.b));
                if (e.req) begin
                    lx[i] = e.h;
                    ly[i] = e.v;
                end
                if (fs[i] === 1'b1) begin
                    if (fs_first[i] < 0) fs_first[i] = n;
                    else if (fs_second[i] < 0) fs_second[i] = n;
                end
            end
            if (hs_prev && hs[0] === 1'b0) begin
                if (hs_fall1 < 0) hs_fall1 = n;
                else if (hs_fall2 < 0) hs_fall2 = n;
            end
            if (!hs_prev && hs[0] === 1'b1 && hs_rise1 < 0) hs_rise1 = n;
            hs_prev = (hs[0] === 1'b1);
        end
    end

    initial begin : main
        bit found;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Several lines of default timing and many small frames.
        repeat (3400) @(posedge clk);
        #1;
        chk("hs_first_fall_clk", 0, hs_fall1, 1316);
        chk("hs_low_clks", 0, hs_rise1 - hs_fall1, 192);
        chk("hs_period_clks", 0, hs_fall2 - hs_fall1, 1600);
        chk("fs_first_clk", 1, fs_first[1], 3);
        chk("fs_period_clks", 1, fs_second[1] - fs_first[1], 196);
        chk("fs_first_clk", 2, fs_first[2], 7);
        chk("fs_period_clks", 2, fs_second[2] - fs_first[2], 392);

        // Reset the small raster while it requests pixel (5,2).
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (preq[1] === 1'b1 && px[1] == 10'd5 && py[1] == 10'd2) found = 1'b1;
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL midframe_wait inst=1 got=timeout want=pixel(5,2)");
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (450) @(posedge clk);
        #1;
        chk("fs_first_after_rst", 1, fs_first[1], 3);
        chk("fs_second_after_rst", 1, fs_second[1], 199);
        chk("fs_first_after_rst", 2, fs_first[2], 7);

        // Random run lengths with random-length resets at random phases.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(50, 1500)) @(posedge clk);
            #1 rst = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 rst = 1'b0;
        end
        repeat (500) @(posedge clk);
        #1;
        chk("fs_first_final", 1, fs_first[1], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
